// File: rtl/zp_sub_array_if.sv
// rtl/zp_sub_array_if.sv - input/output beat streams of the zero-point subtractor
// Purpose: groups the input beat handshake (valid/ready/channel/data) and the
//          output beat handshake (valid/ready/data/saturation flags).
// Ports (signals):
//   in_valid_i, in_ready_o, in_ch_i[CH_W], in_data_i[LANES*DATA_W]
//   out_valid_o, out_ready_i, out_data_o[LANES*OUT_W], out_sat_o[LANES]
// Modports: master drives beats into the block and consumes results;
//           slave is the zp_sub_array side.
`timescale 1ns/1ps
interface zp_sub_array_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int OUT_W  = 32,
    parameter int CH_W   = 3
);
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [CH_W-1:0]         in_ch_i;
    logic [LANES*DATA_W-1:0] in_data_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [LANES*OUT_W-1:0]  out_data_o;
    logic [LANES-1:0]        out_sat_o;

    modport master (
        output in_valid_i, in_ch_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_sat_o
    );

    modport slave (
        input  in_valid_i, in_ch_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_sat_o
    );
endinterface

// File: rtl/zp_sub_array.sv
// rtl/zp_sub_array.sv - multi-lane, multi-channel zero-point subtractor with 2-entry output buffer
// Purpose: subtracts a per-lane, per-channel zero point (from a loadable table)
//          from each beat of signed accumulator values; beats for unloaded
//          channels are consumed and flagged on the sticky err_o.
// Ports:
//   clk_i, rst_i (async, active-high), clr_i (sync clear of loaded bits, buffer, err_o)
//   zp_wr_i, zp_addr_i[CH_W], zp_data_i[LANES*ZP_W]   table write port
//   bus (zp_sub_array_if.slave)                      input and output beat streams
//   err_o                                            sticky dropped-beat flag
// Option: define ZP_SUB_SAT_EN to clamp results to OUT_W and report out_sat_o;
//         otherwise results wrap to the low OUT_W bits and out_sat_o is 0.
`timescale 1ns/1ps
module zp_sub_array #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int ZP_W   = 32,
    parameter int OUT_W  = 32,
    parameter int NUM_CH = 8,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   zp_wr_i,
    input  logic [CH_W-1:0]        zp_addr_i,
    input  logic [LANES*ZP_W-1:0]  zp_data_i,
    zp_sub_array_if.slave          bus,
    output logic                   err_o
);
    // Difference width that can never overflow, widened to OUT_W when the
    // output is wider so the narrowing slice below is always legal.
    localparam int DW = ((DATA_W > ZP_W) ? DATA_W : ZP_W) + 1;
    localparam int EW = (OUT_W > DW) ? OUT_W : DW;
    localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

    logic [LANES*ZP_W-1:0]  zp_tab [NUM_CH];
    logic [NUM_CH-1:0]      loaded;
    logic [LANES*OUT_W-1:0] mem_d [2];
    logic [LANES-1:0]       mem_s [2];
    logic                   rd_ptr, wr_ptr;
    logic [1:0]             count;

    logic                   wr_ok, ch_ok, bypass, hit, accept, push, pop;
    logic [LANES*ZP_W-1:0]  zp_sel;
    logic [LANES*OUT_W-1:0] res;
    logic [LANES-1:0]       sat;
    logic signed [EW-1:0]   d_ext, z_ext;
`ifdef ZP_SUB_SAT_EN
    logic signed [EW-1:0]   diff;
`endif

    assign bus.in_ready_o  = (count != 2'd2);
    assign bus.out_valid_o = (count != 2'd0);
    assign bus.out_data_o  = bus.out_valid_o ? mem_d[rd_ptr] : '0;
    assign bus.out_sat_o   = bus.out_valid_o ? mem_s[rd_ptr] : '0;

    assign accept = bus.in_valid_i && bus.in_ready_o;
    assign pop    = bus.out_valid_o && bus.out_ready_i;
    // A beat for an unloaded channel is consumed but never reaches the buffer.
    assign push   = accept && hit && !clr_i;

    always_comb begin
        wr_ok  = zp_wr_i && ({1'b0, zp_addr_i} < NCH);
        ch_ok  = {1'b0, bus.in_ch_i} < NCH;
        // Same-cycle write to the beat's channel is forwarded to the beat.
        bypass = wr_ok && (zp_addr_i == bus.in_ch_i);
        zp_sel = '0;
        if (bypass) begin
            zp_sel = zp_data_i;
        end else if (ch_ok) begin
            zp_sel = zp_tab[bus.in_ch_i];
        end
        hit   = ch_ok && (bypass || loaded[bus.in_ch_i]);
        res   = '0;
        sat   = '0;
        d_ext = '0;
        z_ext = '0;
`ifdef ZP_SUB_SAT_EN
        diff  = '0;
`endif
        for (int k = 0; k < LANES; k++) begin
            d_ext = {{(EW-DATA_W){bus.in_data_i[k*DATA_W+DATA_W-1]}}, bus.in_data_i[k*DATA_W +: DATA_W]};
            z_ext = {{(EW-ZP_W){zp_sel[k*ZP_W+ZP_W-1]}}, zp_sel[k*ZP_W +: ZP_W]};
`ifdef ZP_SUB_SAT_EN
            diff = d_ext - z_ext;
            // Fits in OUT_W only if all bits from OUT_W-1 upward agree.
            if (!((&diff[EW-1:OUT_W-1]) || !(|diff[EW-1:OUT_W-1]))) begin
                res[k*OUT_W +: OUT_W] = diff[EW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                   : {1'b0, {(OUT_W-1){1'b1}}};
                sat[k] = 1'b1;
            end else begin
                res[k*OUT_W +: OUT_W] = diff[OUT_W-1:0];
            end
`else
            res[k*OUT_W +: OUT_W] = OUT_W'(d_ext - z_ext);
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                zp_tab[i] <= '0;
            end
            loaded   <= '0;
            mem_d[0] <= '0;
            mem_d[1] <= '0;
            mem_s[0] <= '0;
            mem_s[1] <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            err_o    <= 1'b0;
        end else begin
            if (wr_ok) begin
                zp_tab[zp_addr_i] <= zp_data_i;
            end
            if (clr_i) begin
                loaded <= '0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count  <= 2'd0;
                err_o  <= 1'b0;
            end else begin
                if (accept && !hit) begin
                    err_o <= 1'b1;
                end
                if (push) begin
                    mem_d[wr_ptr] <= res;
                    mem_s[wr_ptr] <= sat;
                    wr_ptr        <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
            // Placed after the clear so a same-cycle write keeps its entry loaded.
            if (wr_ok) begin
                loaded[zp_addr_i] <= 1'b1;
            end
        end
    end
endmodule

// File: doc/zp_sub_array.md
# zp_sub_array

Multi-lane, multi-channel successor to the single-lane zero-point subtractor. It sits between the systolic array accumulator drain and the requantiser. Each beat carries LANES signed accumulator values and a channel index; the block subtracts a per-lane, per-channel zero point from a loadable table. Results go through a 2-entry output buffer with valid/ready backpressure.

## Interface
- LANES, default 4: lanes per beat.
- DATA_W, default 32: signed input width per lane.
- ZP_W, default 32: signed zero-point width per lane.
- OUT_W, default 32: signed output width per lane.
- NUM_CH, default 8: zero-point table depth, ≥2; CH_W = $clog2(NUM_CH).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- clr_i  in  1  synchronous clear: loaded flags, buffer, err_o.
- zp_wr_i  in  1  table write strobe.
- zp_addr_i  in  CH_W  table write address.
- zp_data_i  in  LANES*ZP_W  zero points; lane k at [k*ZP_W +: ZP_W].
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block can accept a beat.
- in_ch_i  in  CH_W  channel index of the beat.
- in_data_i  in  LANES*DATA_W  packed signed inputs.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  LANES*OUT_W  packed signed results.
- out_sat_o  out  LANES  per-lane saturation flags (see Configuration).
- err_o  out  1  sticky: a beat was dropped for an unloaded channel.

## Operation
- Table: NUM_CH entries of LANES*ZP_W, plus a loaded bit per entry.
  - zp_wr_i writes the entry and sets its loaded bit.
  - Addresses ≥ NUM_CH are ignored.
- Accept: a beat is accepted when in_valid_i && in_ready_o.
- Bypass: if zp_wr_i writes in_ch_i in the same cycle a beat is accepted, the beat uses zp_data_i and counts as loaded.
- Arithmetic per lane:
  - diff = sext(data) − sext(zp), computed at max(DATA_W,ZP_W)+1 bits, so it never overflows internally.
  - The result is narrowed to OUT_W according to Configuration.
- Unloaded channel: the beat is still accepted (consumed) but is not written to the buffer, and err_o is set. err_o stays high until clr_i or reset.
- Buffer: 2-entry FIFO; the head drives out_*.
  - in_ready_o = (count != 2). This depends only on state and has no combinational path from out_ready_i.
  - Push and pop in the same cycle leave the count unchanged.
- Out-of-range in_ch_i (≥ NUM_CH): treated as unloaded.
- clr_i:
  - Empties the buffer and clears all loaded bits and err_o.
  - Table data is kept.
  - A beat accepted in the same cycle is dropped. A zp_wr_i in the same cycle wins for its entry's loaded bit.
- Reset (asynchronous, any time, including mid-stream):
  - out_valid_o=0, out_data_o=0, out_sat_o=0, err_o=0, in_ready_o=1.
  - Buffer emptied, all loaded bits 0, table data 0.

## Timing
- Latency: a beat accepted at edge N appears on out_valid_o/out_data_o after edge N (visible in cycle N+1) if the buffer was empty.
- Throughput: 1 beat/cycle while out_ready_i=1.
- out_data_o and out_sat_o hold steady while out_valid_o && !out_ready_i.
- Full buffer (count=2): in_ready_o=0 for that cycle even if out_ready_i=1. The first pop re-opens the input on the next cycle.
- Order is strictly preserved; dropped beats leave no gap marker.
- A table write at edge N affects beats accepted at edge N (bypass) and later.

## Configuration
- ZP_SUB_SAT_EN defined:
  - diff is clamped to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - out_sat_o[k]=1 when lane k was clamped.
- ZP_SUB_SAT_EN undefined:
  - diff wraps; out_data_o takes the low OUT_W bits.
  - out_sat_o is tied to 0.

## Test plan
- Load ch3 zp={5,−5,0,100}, send ch3 data={10,10,−7,0} with out_ready_i=1 -> next cycle out_valid_o=1, data={5,15,−7,−100}, err_o=0.
- Write ch1 zp={1,1,1,1} in the same cycle as beat ch1 data={0,0,0,0}, with ch1 previously unloaded -> output {−1,−1,−1,−1}, err_o stays 0.
- Beat on never-loaded ch6 -> beat accepted, no output, err_o=1 until clr_i; after clr_i, ch3 (loaded earlier) beats are dropped until it is rewritten.
- out_ready_i=0, send 3 beats back-to-back -> in_ready_o falls after 2 accepts; raise out_ready_i -> beats emerge in order with unchanged data.
- OUT_W=16, data=40000, zp=0:
  - With ZP_SUB_SAT_EN -> 32767, out_sat_o[0]=1.
  - Without -> −25536, out_sat_o=0.
- Assert rst_i asynchronously mid-edge with 2 beats buffered -> out_valid_o=0 immediately, in_ready_o=1; after release, a beat on a previously loaded channel sets err_o=1.
